// File: rtl/ftdi_frame_scheduler.sv
// ftdi_frame_scheduler: round-robin arbiter sharing one FTDI byte channel
// between N_SRC 64-bit word sources. Each granted word is sent as a frame:
// SYNC_BYTE, header {seq, id}, then 8 data bytes MSB first.
// Optional macro FTDI_FRAME_CHECKSUM_EN appends an XOR checksum byte
// (header ^ data bytes) after the data bytes.
module ftdi_frame_scheduler #(
    parameter int          N_SRC     = 4,
    parameter logic [7:0]  SYNC_BYTE = 8'hA5
) (
    input  logic                  clk_pll,
    input  logic                  rst,
    input  logic [N_SRC-1:0]      src_req,
    input  logic [64*N_SRC-1:0]   src_data,
    output logic [N_SRC-1:0]      src_ack,
    input  logic                  ftdi_full,
    output logic                  ftdi_wr_en,
    output logic [7:0]            ftdi_data,
    output logic                  busy
);

`ifdef FTDI_FRAME_CHECKSUM_EN
    typedef enum logic [2:0] {IDLE, SYNC, HDR, DATA, CSUM} state_t;
`else
    typedef enum logic [2:0] {IDLE, SYNC, HDR, DATA} state_t;
`endif

    state_t             state, state_nxt;
    logic [63:0]        shreg;
    logic [2:0]         byte_cnt;
    logic [3:0]         seq;
    logic [3:0]         id;
    logic [3:0]         rr_ptr;
    logic [N_SRC-1:0]   ack_q;
    logic [7:0]         data_q;
    logic               accept;

    logic [3:0]         gnt, gnt_hi, gnt_lo;
    logic               hi_vld;
    logic [N_SRC-1:0]   gnt_oh;
`ifdef FTDI_FRAME_CHECKSUM_EN
    logic [7:0]         csum;
`endif

    // Round-robin pick: lowest requester at or above rr_ptr, else lowest overall
    always_comb begin
        gnt_hi = '0;
        gnt_lo = '0;
        hi_vld = 1'b0;
        for (int i = N_SRC - 1; i >= 0; i--) begin
            if (src_req[i]) begin
                gnt_lo = 4'(i);
                if (4'(i) >= rr_ptr) begin
                    gnt_hi = 4'(i);
                    hi_vld = 1'b1;
                end
            end
        end
        gnt    = hi_vld ? gnt_hi : gnt_lo;
        gnt_oh = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (4'(i) == gnt) gnt_oh[i] = 1'b1;
        end
    end

    // State register
    always_ff @(posedge clk_pll) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state: advance only when the current byte is accepted
    always_comb begin
        state_nxt = state;
        accept    = (state != IDLE) && !ftdi_full;
        case (state)
            IDLE: if (|src_req) state_nxt = SYNC;
            SYNC: if (accept)   state_nxt = HDR;
            HDR:  if (accept)   state_nxt = DATA;
            DATA: if (accept && byte_cnt == 3'd7) begin
`ifdef FTDI_FRAME_CHECKSUM_EN
                state_nxt = CSUM;
`else
                state_nxt = IDLE;
`endif
            end
`ifdef FTDI_FRAME_CHECKSUM_EN
            CSUM: if (accept)   state_nxt = IDLE;
`endif
            default:            state_nxt = IDLE;
        endcase
    end

    // Datapath: capture word, load the byte register one step ahead of each state
    always_ff @(posedge clk_pll) begin
        if (rst) begin
            shreg    <= '0;
            byte_cnt <= '0;
            seq      <= '0;
            id       <= '0;
            rr_ptr   <= '0;
            ack_q    <= '0;
            data_q   <= '0;
`ifdef FTDI_FRAME_CHECKSUM_EN
            csum     <= '0;
`endif
        end else begin
            ack_q <= '0;
            case (state)
                IDLE: if (|src_req) begin
                    shreg    <= src_data[{gnt, 6'd0} +: 64];
                    ack_q    <= gnt_oh;
                    id       <= gnt;
                    rr_ptr   <= (gnt == 4'(N_SRC - 1)) ? 4'd0 : gnt + 4'd1;
                    data_q   <= SYNC_BYTE;
                    byte_cnt <= '0;
                end
                SYNC: if (accept) data_q <= {seq, id};
                HDR: if (accept) begin
                    data_q <= shreg[63:56];
                    shreg  <= shreg << 8;
`ifdef FTDI_FRAME_CHECKSUM_EN
                    csum   <= data_q;
`endif
                end
                DATA: if (accept) begin
`ifdef FTDI_FRAME_CHECKSUM_EN
                    csum <= csum ^ data_q;
`endif
                    if (byte_cnt == 3'd7) begin
`ifdef FTDI_FRAME_CHECKSUM_EN
                        data_q <= csum ^ data_q;
`else
                        data_q <= 8'h00;
                        seq    <= seq + 4'd1;
`endif
                    end else begin
                        data_q   <= shreg[63:56];
                        shreg    <= shreg << 8;
                        byte_cnt <= byte_cnt + 3'd1;
                    end
                end
`ifdef FTDI_FRAME_CHECKSUM_EN
                CSUM: if (accept) begin
                    data_q <= 8'h00;
                    seq    <= seq + 4'd1;
                end
`endif
                default: ;
            endcase
        end
    end

    assign ftdi_wr_en = accept;
    assign ftdi_data  = data_q;
    assign busy       = (state != IDLE);
    assign src_ack    = ack_q;

endmodule

// File: tb/tb_ftdi_frame_scheduler.sv
// Scoreboard bench for ftdi_frame_scheduler: a frame-level reference model
// queues expected bytes / acks / busy; a negedge monitor compares.
module tb_ftdi_frame_scheduler;
    localparam int NS = 4;
`ifdef FTDI_FRAME_CHECKSUM_EN
    localparam int FLEN = 11;
`else
    localparam int FLEN = 10;
`endif

    logic                clk_pll = 1'b0;
    logic                rst;
    logic [NS-1:0]       src_req;
    logic [64*NS-1:0]    src_data;
    logic [NS-1:0]       src_ack;
    logic                ftdi_full;
    logic                ftdi_wr_en;
    logic [7:0]          ftdi_data;
    logic                busy;

    ftdi_frame_scheduler #(.N_SRC(NS), .SYNC_BYTE(8'hA5)) dut (
        .clk_pll(clk_pll), .rst(rst), .src_req(src_req), .src_data(src_data),
        .src_ack(src_ack), .ftdi_full(ftdi_full), .ftdi_wr_en(ftdi_wr_en),
        .ftdi_data(ftdi_data), .busy(busy)
    );

    always #5 clk_pll = ~clk_pll;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // per-source pending words (the requesters)
    logic [63:0] pmem [NS][64];
    int          phead [NS];
    int          ptail [NS];

    task automatic push(input int s, input logic [63:0] w);
        pmem[s][ptail[s] % 64] = w;
        ptail[s]++;
    endtask

    function automatic int pending();
        int t = 0;
        for (int i = 0; i < NS; i++) t += ptail[i] - phead[i];
        return t;
    endfunction

    // requester driver: drop a word once acked, present the next one
    initial begin
        src_req  = '0;
        src_data = '0;
        for (int i = 0; i < NS; i++) begin phead[i] = 0; ptail[i] = 0; end
        forever begin
            @(posedge clk_pll); #1;
            for (int i = 0; i < NS; i++)
                if (src_ack[i] === 1'b1 && ptail[i] > phead[i]) phead[i]++;
            for (int i = 0; i < NS; i++) begin
                src_req[i]         = ptail[i] > phead[i];
                src_data[64*i +: 64] = (ptail[i] > phead[i]) ? pmem[i][phead[i] % 64] : 64'h0;
            end
        end
    end

    // reference model: frame-level view of the scheduler
    logic [7:0]    exp_q [$];
    logic          m_busy = 1'b0;
    logic [NS-1:0] m_ack  = '0;
    int            m_left = 0, m_ptr = 0, m_seq = 0, m_g, m_idx;
    logic [63:0]   m_w;
    logic [7:0]    m_hdr, m_cs;

    initial forever begin
        @(posedge clk_pll);
        if (rst) begin
            m_busy = 1'b0; m_ptr = 0; m_seq = 0; m_left = 0; m_ack = '0;
            exp_q.delete();
        end else begin
            m_ack = '0;
            if (!m_busy) begin
                if (src_req != '0) begin
                    m_g = -1;
                    for (int k = 0; k < NS; k++) begin
                        m_idx = (m_ptr + k) % NS;
                        if (m_g < 0 && src_req[m_idx]) m_g = m_idx;
                    end
                    m_w = src_data[64*m_g +: 64];
                    m_ack[m_g] = 1'b1;
                    m_hdr = {4'(m_seq), 4'(m_g)};
                    exp_q.push_back(8'hA5);
                    exp_q.push_back(m_hdr);
                    m_cs = m_hdr;
                    for (int b = 7; b >= 0; b--) begin
                        exp_q.push_back(m_w[8*b +: 8]);
                        m_cs ^= m_w[8*b +: 8];
                    end
`ifdef FTDI_FRAME_CHECKSUM_EN
                    exp_q.push_back(m_cs);
`endif
                    m_left = FLEN;
                    m_busy = 1'b1;
                    m_ptr  = (m_g + 1) % NS;
                end
            end else begin
                if (!ftdi_full) m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_seq  = (m_seq + 1) % 16;
                end
            end
        end
    end

    // monitor: compare DUT against the model every cycle, log writes
    logic       mon_en = 1'b0;
    logic [7:0] wr_log [$];
    logic [7:0] hdr_log [$];
    int         len_log [$];
    int         pos = 0, run = 0;

    initial forever begin
        @(negedge clk_pll);
        if (mon_en) begin
            chk("busy", busy, m_busy);
            chk("src_ack", src_ack, m_ack);
            if (!busy) begin
                chk("idle_data", ftdi_data, 8'h00);
                chk("idle_wr_en", ftdi_wr_en, 1'b0);
            end
            if (ftdi_wr_en) begin
                chk("wr_while_full", ftdi_full, 1'b0);
                if (exp_q.size() == 0) chk("unexpected_write", 1'b1, 1'b0);
                else chk("byte", ftdi_data, exp_q.pop_front());
                wr_log.push_back(ftdi_data);
                if (pos == 1) hdr_log.push_back(ftdi_data);
                pos++;
            end else if (busy && exp_q.size() > 0) begin
                chk("held_byte", ftdi_data, exp_q[0]);
            end
            if (busy) run++;
            else begin
                if (run > 0) len_log.push_back(run);
                run = 0;
                pos = 0;
            end
        end
    end

    task automatic clear_logs();
        wr_log.delete(); hdr_log.delete(); len_log.delete();
    endtask

    task automatic do_reset();
        @(posedge clk_pll); #2; rst = 1'b1;
        @(posedge clk_pll); #2; rst = 1'b0;
        clear_logs();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((pending() > 0 || busy || exp_q.size() > 0) && n < 3000) begin
            @(posedge clk_pll); #2; n++;
        end
        @(posedge clk_pll); #2;
        if (n >= 3000) chk("idle_timeout", 1'b1, 1'b0);
    endtask

    task automatic wait_ack(input int s);
        int n = 0;
        while (src_ack[s] !== 1'b1 && n < 200) begin @(posedge clk_pll); #2; n++; end
        if (n >= 200) chk("ack_timeout", 1'b1, 1'b0);
    endtask

    logic [7:0] basic_exp [10] = '{8'hA5, 8'h00, 8'hAF, 8'hFA, 8'hAF, 8'hFA, 8'hAF, 8'hFA, 8'hAF, 8'hFA};

    initial begin
        rst = 1'b1;
        ftdi_full = 1'b0;
        repeat (3) @(posedge clk_pll);
        #2;
        chk("rst_src_ack", src_ack, '0);
        chk("rst_wr_en", ftdi_wr_en, 1'b0);
        chk("rst_data", ftdi_data, 8'h00);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        mon_en = 1'b1;
        clear_logs();

        // basic frame
        push(0, 64'haffaaffaaffaaffa);
        wait_idle();
        chk("basic_nbytes", wr_log.size(), 10);
        for (int k = 0; k < 10; k++) chk("basic_byte", wr_log[k], basic_exp[k]);
        chk("basic_len", len_log.size() > 0 ? len_log[0] : -1, FLEN);

        // round robin, all four requesting
        do_reset();
        for (int r = 0; r < 2; r++)
            for (int s = 0; s < NS; s++) push(s, 64'(s));
        wait_idle();
        chk("rr_nhdr", hdr_log.size(), 8);
        for (int k = 0; k < 5; k++) chk("rr_hdr", hdr_log[k], {4'(k), 4'(k % 4)});

        // backpressure for 5 cycles on the 3rd data byte
        do_reset();
        push(0, 64'h0011223344556677);
        wait_ack(0);
        repeat (4) begin @(posedge clk_pll); #2; end
        ftdi_full = 1'b1;
        repeat (5) begin @(posedge clk_pll); #2; end
        ftdi_full = 1'b0;
        wait_idle();
        chk("bp_nbytes", wr_log.size(), FLEN);
        chk("bp_len", len_log.size() > 0 ? len_log[0] : -1, FLEN + 5);

        // reset after the 4th data byte
        do_reset();
        push(1, 64'h1122334455667788);
        wait_ack(1);
        repeat (6) begin @(posedge clk_pll); #2; end
        rst = 1'b1;
        @(posedge clk_pll); #2;
        rst = 1'b0;
        chk("midrst_wr_en", ftdi_wr_en, 1'b0);
        chk("midrst_busy", busy, 1'b0);
        chk("midrst_data", ftdi_data, 8'h00);
        hdr_log.delete();
        push(3, 64'hdeadbeefcafef00d);
        wait_idle();
        chk("midrst_next_hdr", hdr_log.size() > 0 ? hdr_log[0] : 8'hxx, 8'h03);

        // seq wrap with a single requester
        do_reset();
        for (int k = 0; k < 17; k++) push(2, {$urandom, $urandom});
        wait_idle();
        chk("wrap_nhdr", hdr_log.size(), 17);
        for (int k = 0; k < 17; k++) chk("wrap_hdr", hdr_log[k], {4'(k % 16), 4'd2});

`ifdef FTDI_FRAME_CHECKSUM_EN
        do_reset();
        push(1, 64'h0102030405060708);
        wait_idle();
        chk("csum_byte", wr_log.size() > 10 ? wr_log[10] : 8'hxx, 8'h09);
`endif

        // randomized traffic and backpressure
        do_reset();
        for (int c = 0; c < 600; c++) begin
            @(posedge clk_pll); #2;
            ftdi_full = ($urandom % 4) == 0;
            if (($urandom % 3) == 0) begin
                int s;
                s = int'($urandom % NS);
                if (ptail[s] - phead[s] < 3) push(s, {$urandom, $urandom});
            end
        end
        ftdi_full = 1'b0;
        wait_idle();
        chk("final_queue_empty", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ftdi_frame_scheduler.md
# ftdi_frame_scheduler

Round-robin scheduler that shares the single FTDI byte channel between `N_SRC` 64-bit word requesters, such as per-microphone-group sample packers. Each granted word is sent as a framed burst: sync byte, header byte (sequence number and source ID), then 8 data bytes MSB first, with writes throttled by `ftdi_full`. The block sits between the sample-packing logic and the FTDI FIFO pins, in the `clk_pll` domain.

## Interface
- `N_SRC`, default 4: number of requesters, 1..16.
- `SYNC_BYTE`, default 8'hA5: first byte of every frame.

- `clk_pll` input, 1 bit: single clock. All logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `src_req` input, `N_SRC` bits: per-source request level. Source i holds `src_req[i]` until it sees `src_ack[i]`.
- `src_data` input, 64*`N_SRC` bits: source i word at `[64*i+63 : 64*i]`. It must be stable while `src_req[i]` is high.
- `src_ack` output, `N_SRC` bits: one-cycle pulse marking the edge at which the word was captured.
- `ftdi_full` input, 1 bit: FTDI FIFO full. No write occurs in any cycle where it is high.
- `ftdi_wr_en` output, 1 bit: byte write strobe.
- `ftdi_data` output, 8 bits: byte being written.
- `busy` output, 1 bit: high when the state is not IDLE.

## Operation
- **States:** IDLE, SYNC, HDR, DATA, CSUM (CSUM exists only with the macro).
- **IDLE:** if any `src_req` bit is high, the arbiter picks grant `g` round-robin, then on the same edge:
  - `src_data[g]` is captured into a 64-bit shift register;
  - `src_ack[g]` is registered high for exactly the next cycle;
  - the state moves to SYNC.
- **Round-robin order:** search starts at (last grant + 1) mod `N_SRC`. After reset the search starts at source 0.
- **Byte order:**
  - SYNC emits `SYNC_BYTE`.
  - HDR emits {seq[3:0], id[3:0]}, where id is `g` zero-extended.
  - DATA emits bytes [63:56] down to [7:0] through a left shift of 8 bits per accepted byte, tracked by a 3-bit byte counter.
- **Byte acceptance:** a byte is accepted in a cycle where the state is SYNC, HDR, DATA or CSUM and `ftdi_full` = 0. The state or counter advances only on acceptance. When `ftdi_full` = 1, the state, counter and `ftdi_data` all hold.
- **End of frame:** after the 8th data byte is accepted, the state goes to IDLE, or to CSUM when the macro is compiled in.
- **seq:** 4-bit frame counter, incremented once per completed frame, wrapping 15 to 0. A frame is complete when its last byte is accepted. The frame currently in flight carries the pre-increment value.
- **Requests during a frame:** requests arriving mid-frame wait. `src_req` is sampled only in IDLE.

## Timing
- `ftdi_wr_en` = (state is SYNC, HDR, DATA or CSUM) AND NOT `ftdi_full`. This is combinational from registered state and the `ftdi_full` pin. There is no registered lag, so no write can ever occur while full.
- `ftdi_data` comes from a register (the current byte mux of state and shift register). It is valid whenever the state is not IDLE and is 8'h00 in IDLE.
- **Latency:** the request is sampled at edge N. `src_ack` is high in cycle N+1, and the sync byte is written in cycle N+1 if not full.
- **Frame period with `ftdi_full` held low:** 10 write cycles plus 1 IDLE cycle, i.e. 11 cycles per frame (12 with checksum).
- **Reset values:**
  - outputs: `src_ack` = 0, `ftdi_wr_en` = 0, `ftdi_data` = 0, `busy` = 0;
  - internal: state = IDLE, seq = 0, round-robin pointer favours source 0, shift register = 0.
- **Reset mid-frame:** the partial frame is abandoned with no further writes. A source that was already acked is not re-served.
- **All requests high continuously:** grants go 0, 1, 2, …, `N_SRC`-1, 0, …
- **Single requester:** that source is re-granted on every IDLE visit.
- **`ftdi_full` high for K cycles on any byte:** the frame is stretched by exactly K cycles, and no byte is duplicated or dropped.

## Configuration
- **`FTDI_FRAME_CHECKSUM_EN` defined:**
  - the CSUM state is added after the 8th data byte;
  - it emits the XOR of the header byte and the 8 data bytes;
  - frames are 11 bytes, and seq increments when the CSUM byte is accepted.
- **Not defined:** there is no CSUM state, frames are 10 bytes, and the checksum logic is not built.

## Test plan
- **Basic frame:** reset, then `src_req` = 4'b0001 with source 0 = 64'haffaaffaaffaaffa and `ftdi_full` = 0.
  - Required: `src_ack[0]` high for one cycle.
  - Required bytes: A5, 00, AF, FA, AF, FA, AF, FA, AF, FA on 10 consecutive `ftdi_wr_en` cycles.
  - Required: `busy` drops on the next cycle.
- **Round-robin:** all 4 requests held high with words 0, 1, 2, 3, re-raising each request after its ack.
  - Required header bytes: 00, 11, 22, 33, 40 (seq increments, ids cycle 0 through 3 and back to 0).
- **Backpressure:** `ftdi_full` = 1 for 5 cycles during the 3rd data byte.
  - Required: `ftdi_wr_en` = 0 for those 5 cycles and `ftdi_data` held.
  - Required: the full 10-byte sequence is intact and the frame takes 15 cycles.
- **Reset mid-frame:** assert `rst` after the 4th data byte.
  - Required: the next cycle has `ftdi_wr_en` = 0, `busy` = 0 and `ftdi_data` = 00.
  - Required: the next frame's header has seq = 0.
- **seq wrap:** send 17 frames from source 2.
  - Required: headers 02, 12, …, F2, 02.
- **Checksum:** with `FTDI_FRAME_CHECKSUM_EN` defined, source 1 = 64'h0102030405060708 and seq = 0.
  - Required: the 11th byte is 8'h09, since header 01 XOR 01 XOR 02 XOR … XOR 08 = 09.
